tristate_bus_reader: RTL

- Receive-side endpoint of a shared tri-state data bus. Remote drivers place a word on the bus through enable-gated tri-state buffers and hold the enable high while driving.
- The block synchronizes the enable, waits for the bus to settle, and captures one word per enable pulse.
- Captured words are queued in a small FIFO and presented to local logic on a valid/ready interface.
- A hold output gives back-pressure to the drivers when the FIFO is full.

---
 rtl/tristate_bus_reader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tristate_bus_reader.sv
// Receive endpoint for a shared tri-state bus: synchronizes the driver enable, waits for
// settle, captures one word per enable pulse into a FIFO. Optional parity: BUS_PARITY_CHECK_EN.
module tristate_bus_reader #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         bus_data,
    input  logic                     bus_en,
`ifdef BUS_PARITY_CHECK_EN
    input  logic                     bus_par,
    output logic                     rd_perr,
`endif
    output logic                     bus_hold,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    input  logic                     clr_err,
    output logic                     overflow,
    output logic                     glitch,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
`ifdef BUS_PARITY_CHECK_EN
    localparam int unsigned FW = WIDTH + 1;
`else
    localparam int unsigned FW = WIDTH;
`endif
    localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_WAIT_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_en_s;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_glitch;

    logic [FW-1:0]          r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW:0]            r_count;
    logic                   r_valid;
    logic                   r_hold;
    logic                   r_overflow;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_wr_en;
    logic [PW:0]            w_count_nxt;
    logic [FW-1:0]          w_push_word;
    logic [FW-1:0]          w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus_en};
        end
    end

    assign w_en_s = r_sync[SYNC_STAGES-1];

    // clr_err is applied first so a same-cycle glitch event overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_glitch <= 1'b0;
        end else begin
            if (clr_err) begin
                r_glitch <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_en_s) begin
                        r_cnt   <= SETTLE_LD;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!w_en_s) begin
                        r_glitch <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!w_en_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BUS_PARITY_CHECK_EN
    assign w_push_word = {bus_par, bus_data};
`else
    assign w_push_word = bus_data;
`endif

    assign w_push  = (r_state == S_CAPTURE);
    assign w_pop   = r_valid && rd_ready;
    assign w_full  = (r_count == FULL_CNT);
    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_en, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_hold     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_push_word;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_hold  <= (w_count_nxt == FULL_CNT);
            if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign rd_data    = w_head[WIDTH-1:0];
    assign rd_valid   = r_valid;
    assign bus_hold   = r_hold;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign glitch     = r_glitch;

`ifdef BUS_PARITY_CHECK_EN
    assign rd_perr = r_valid && (^w_head);
`endif

endmodule
